// File: rtl/ks_pkg.sv
// ks_pkg: shared propagate/generate type and helpers for the Kogge-Stone adder.
package ks_pkg;
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;
  function automatic pg_t pg_combine(pg_t hi, pg_t lo);
    return '{p: hi.p & lo.p, g: hi.g | (hi.p & lo.g)};
  endfunction
  function automatic int ceil_div(int n, int d);
    return (n + d - 1) / d;
  endfunction
endpackage

// File: rtl/ks_prefix_group.sv
// ks_prefix_group: combinational span of NUM_LEVELS Kogge-Stone levels starting at FIRST_LEVEL.
module ks_prefix_group
  import ks_pkg::*;
#(
  parameter int NBITS       = 32,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1
) (
  input  pg_t [NBITS:0] pg_i,
  output pg_t [NBITS:0] pg_o
);
  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lvl
    localparam int D = 1 << (FIRST_LEVEL + l);
    pg_t [NBITS:0] src;
    pg_t [NBITS:0] nd;
    if (l == 0) begin : g_first
      assign src = pg_i;
    end else begin : g_next
      assign src = g_lvl[l-1].nd;
    end
    for (genvar x = 0; x <= NBITS; x++) begin : g_node
      if (x >= D) begin : g_op
        assign nd[x] = pg_combine(src[x], src[x-D]);
      end else begin : g_pass
        assign nd[x] = src[x];
      end
    end
  end
  assign pg_o = g_lvl[NUM_LEVELS-1].nd;
endmodule

// File: rtl/ks_pipe_addsub.sv
// ks_pipe_addsub: pipelined Kogge-Stone adder/subtractor with flags and a globally stalled valid/ready stream.
module ks_pipe_addsub
  import ks_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int DEPTH = $clog2(NBITS);
  localparam int G     = ceil_div(DEPTH, REG_EVERY);
  logic             adv;
  logic [NBITS-1:0] b_eff;
  pg_t  [NBITS:0]   pre_d;
  pg_t  [NBITS:0]   nd_q [G];
  pg_t  [NBITS:0]   grp  [G];
  logic [NBITS-1:0] p_q  [G];
  logic [G-1:0]     v_q, am_q, bm_q;
  logic [NBITS-1:0] sum_d, sum_q;
  logic             cout_d, ovf_d, zero_d;
  logic             out_valid_q, cout_q, ovf_q, zero_q;
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  // prefix position 0 carries the effective carry-in; bit i lives at position i+1
  always_comb begin
    b_eff    = sub ? ~b : b;
    pre_d[0] = '{p: 1'b0, g: sub | cin};
    for (int i = 0; i < NBITS; i++) pre_d[i+1] = '{p: a[i] ^ b_eff[i], g: a[i] & b_eff[i]};
  end
  for (genvar s = 0; s < G; s++) begin : g_grp
    ks_prefix_group #(
      .NBITS      (NBITS),
      .FIRST_LEVEL(s * REG_EVERY),
      .NUM_LEVELS (s == G - 1 ? DEPTH - (G - 1) * REG_EVERY : REG_EVERY)
    ) u_grp (
      .pg_i(nd_q[s]),
      .pg_o(grp[s])
    );
  end
  // top node may span only positions 1..NBITS when NBITS is a power of two, so fold in position 0
  always_comb begin
    for (int i = 0; i < NBITS; i++) sum_d[i] = p_q[G-1][i] ^ grp[G-1][i].g;
    cout_d = grp[G-1][NBITS].g | (grp[G-1][NBITS].p & grp[G-1][0].g);
    ovf_d  = (am_q[G-1] == bm_q[G-1]) && (sum_d[NBITS-1] != am_q[G-1]);
    zero_d = sum_d == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      am_q        <= '0;
      bm_q        <= '0;
      for (int s = 0; s < G; s++) begin
        nd_q[s] <= '0;
        p_q[s]  <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      v_q[0]  <= in_valid;
      nd_q[0] <= pre_d;
      p_q[0]  <= a ^ b_eff;
      am_q[0] <= a[NBITS-1];
      bm_q[0] <= b_eff[NBITS-1];
      for (int s = 1; s < G; s++) begin
        v_q[s]  <= v_q[s-1];
        nd_q[s] <= grp[s-1];
        p_q[s]  <= p_q[s-1];
        am_q[s] <= am_q[s-1];
        bm_q[s] <= bm_q[s-1];
      end
      out_valid_q <= v_q[G-1];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end
endmodule

// File: tb/tb_ks_pipe_addsub.sv
// tb_ks_pipe_addsub: scoreboard bench over 16/1, 24/5 and 32/2 configurations.
module tb_ks_pipe_addsub;
  typedef logic [34:0] exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_err = 0;
  exp_t q16[$], q24[$], q32[$];
  logic        v16, rdy16, cin16, sub16, ov16, ordy16, co16, of16, z16;
  logic [15:0] a16, b16, s16;
  logic        v24, rdy24, cin24, sub24, ov24, ordy24, co24, of24, z24;
  logic [23:0] a24, b24, s24;
  logic        v32, rdy32, cin32, sub32, ov32, ordy32, co32, of32, z32;
  logic [31:0] a32, b32, s32;
  ks_pipe_addsub #(.NBITS(16), .REG_EVERY(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(ordy16), .sum(s16), .cout(co16), .ovf(of16), .zero(z16));
  ks_pipe_addsub #(.NBITS(24), .REG_EVERY(5)) u24 (
    .clk(clk), .rst(rst), .in_valid(v24), .in_ready(rdy24), .a(a24), .b(b24), .cin(cin24), .sub(sub24),
    .out_valid(ov24), .out_ready(ordy24), .sum(s24), .cout(co24), .ovf(of24), .zero(z24));
  ks_pipe_addsub #(.NBITS(32), .REG_EVERY(2)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(ov32), .out_ready(ordy32), .sum(s32), .cout(co32), .ovf(of32), .zero(z32));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s", name);
  endtask
  function automatic exp_t ref32(logic [31:0] a, logic [31:0] b, logic c, logic s);
    logic [31:0] be;
    logic [32:0] f;
    be = s ? ~b : b;
    f  = {1'b0, a} + {1'b0, be} + {32'h0, s | c};
    return {f[31:0], f[32], (a[31] == be[31]) && (f[31] != a[31]), f[31:0] == 32'h0};
  endfunction
  always @(negedge clk) begin
    if (!rst && ov16 && ordy16) begin
      if (q16.size() == 0) fail("u16 stray result");
      else chk("u16 result", {16'h0, s16, co16, of16, z16}, q16.pop_front());
    end
    if (!rst && ov24 && ordy24) begin
      if (q24.size() == 0) fail("u24 stray result");
      else chk("u24 result", {8'h0, s24, co24, of24, z24}, q24.pop_front());
    end
    if (!rst && ov32 && ordy32) begin
      if (q32.size() == 0) fail("u32 stray result");
      else chk("u32 result", {s32, co32, of32, z32}, q32.pop_front());
    end
  end
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s, input exp_t e);
    v16 = 1'b1; a16 = a; b16 = b; cin16 = c; sub16 = s;
    q16.push_back(e);
    @(posedge clk); #1;
    v16 = 1'b0;
  endtask
  task automatic send24(input logic [23:0] a, input logic [23:0] b, input logic c, input logic s, input exp_t e);
    v24 = 1'b1; a24 = a; b24 = b; cin24 = c; sub24 = s;
    q24.push_back(e);
    @(posedge clk); #1;
    v24 = 1'b0;
  endtask
  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s, input exp_t e);
    int k = 0;
    while (!rdy32 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rdy32) fail("send32 in_ready timeout");
    else begin
      v32 = 1'b1; a32 = a; b32 = b; cin32 = c; sub32 = s;
      q32.push_back(e);
      @(posedge clk); #1;
      v32 = 1'b0;
    end
  endtask
  task automatic lat_chk(input string name, input int w, input int exp);
    int k = 0;
    while (!(w == 16 ? ov16 : w == 24 ? ov24 : ov32) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 64'(k), 64'(exp));
  endtask
  task automatic drain(output int k);
    k = 0;
    while ((q16.size() + q24.size() + q32.size()) != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) fail("drain timeout");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int k;
    logic [31:0] ra, rb;
    logic rc, rs;
    logic [34:0] snap;
    v16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; ordy16 = 1;
    v24 = 0; a24 = 0; b24 = 0; cin24 = 0; sub24 = 0; ordy24 = 1;
    v32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; ordy32 = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset out32", {ov32, s32, co32, of32, z32}, 0);
    chk("reset out16", {ov16, s16, co16, of16, z16}, 0);
    chk("reset in_ready32", 64'(rdy32), 1);
    send16(16'hFFFF, 16'h0001, 0, 0, {32'h0000, 3'b101});
    lat_chk("latency16", 16, 4);
    send16(16'h7FFF, 16'h0001, 0, 0, {32'h8000, 3'b010});
    send16(16'h0003, 16'h0005, 0, 1, {32'hFFFE, 3'b000});
    send16(16'h0005, 16'h0003, 0, 1, {32'h0002, 3'b100});
    send16(16'h8000, 16'h0001, 0, 1, {32'h7FFF, 3'b110});
    send16(16'h1234, 16'h4321, 1, 0, {32'h5556, 3'b000});
    send16(16'h0005, 16'h0005, 1, 1, {32'h0000, 3'b101});
    drain(k);
    send24(24'hFFFFFF, 24'hFFFFFF, 1, 0, {32'hFFFFFF, 3'b100});
    lat_chk("latency24", 24, 1);
    send24(24'h000000, 24'h000001, 0, 1, {32'hFFFFFF, 3'b000});
    send24(24'h800000, 24'h800000, 0, 0, {32'h000000, 3'b111});
    drain(k);
    send32(32'hFFFFFFFF, 32'h1, 0, 0, {32'h0, 3'b101});
    lat_chk("latency32", 32, 3);
    send32(32'h7FFFFFFF, 32'h1, 0, 0, {32'h80000000, 3'b010});
    drain(k);
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send32(ra, rb, rc, rs, ref32(ra, rb, rc, rs));
    end
    drain(k);
    chk("stream drain cycles", 64'(k), 4);
    ordy32 = 0;
    send32(32'h10, 32'h20, 0, 0, {32'h30, 3'b000});
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, {32'h0, 3'b101});
    send32(32'h0, 32'h80000000, 0, 1, {32'h80000000, 3'b010});
    k = 0;
    while (!ov32 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp out_valid", 64'(ov32), 1);
    snap = {s32, co32, of32, z32};
    chk("bp head", snap, {32'h30, 3'b000});
    repeat (7) begin
      @(posedge clk); #1;
      chk("bp hold", {ov32, rdy32, s32, co32, of32, z32}, {1'b1, 1'b0, snap});
    end
    ordy32 = 1;
    drain(k);
    ordy32 = 0;
    send32(32'h1, 32'h1, 0, 0, {32'h2, 3'b000});
    send32(32'h2, 32'h2, 0, 0, {32'h4, 3'b000});
    send32(32'h3, 32'h3, 0, 0, {32'h6, 3'b000});
    send32(32'h4, 32'h4, 0, 0, {32'h8, 3'b000});
    rst = 1;
    q32.delete();
    @(posedge clk); #1;
    rst = 0;
    chk("midreset out32", {ov32, s32, co32, of32, z32}, 0);
    chk("midreset in_ready32", 64'(rdy32), 1);
    ordy32 = 1;
    repeat (10) @(posedge clk);
    #1;
    send32(32'h5, 32'h7, 0, 1, {32'hFFFFFFFE, 3'b000});
    lat_chk("latency32 after reset", 32, 3);
    drain(k);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
